multicycle_control: RTL and testbench

FSM controller for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback, issuing one set of datapath strobes per cycle. It supports a stall handshake on the shared instruction/data memory and counts retired instructions. It sits beside the single-cycle decoder, and uses the same shared opcode, funct and ALU_* encodings.

---
 rtl/multicycle_control_if.sv | 42 ++++
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Datapath-facing bundle for the multi-cycle MIPS controller: IR/flag inputs,
// per-cycle datapath strobes, debug state and the retired-instruction counter.
interface multicycle_control_if #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
);
  logic [31:0]        inst;
  logic               mem_ready;
  logic               zero;
  logic               mem_read;
  logic               mem_write;
  logic               iord;
  logic               ir_write;
  logic               pc_write;
  logic [1:0]         pc_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               reg_write;
  logic [1:0]         reg_dst;
  logic [1:0]         reg_src;
  logic [3:0]         state;
  logic               retire;
  logic               illegal;
  logic [CNT_W-1:0]   inst_count;

  // controller side
  modport master (
    input  inst, mem_ready, zero,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, reg_src,
           state, retire, illegal, inst_count
  );

  // datapath side
  modport slave (
    output inst, mem_ready, zero,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, reg_src,
           state, retire, illegal, inst_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// shared-memory stall handshake and a retired-instruction counter.
module multicycle_control #(
  parameter int ALUOP_W  = 4,
  parameter bit STALL_EN = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic clk,
  input  logic rstn,
  multicycle_control_if.master bus
);
  localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(12);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC = 4'd6, S_ALU_WB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] inst_count_q, inst_count_d;

  logic [5:0] op, fn;
  logic is_r, r_ok, r_shift, i_ok, is_jr, is_jalr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic [ALUOP_W-1:0] r_op, i_op;
  logic rdy;
  logic unused_inst_bits;

  assign op      = bus.inst[31:26];
  assign fn      = bus.inst[5:0];
  assign is_r    = (op == 6'h00);
  assign is_jr   = is_r && (fn == 6'h08);
  assign is_jalr = is_r && (fn == 6'h09);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_bne  = (op == 6'h05);
  assign is_j    = (op == 6'h02);
  assign is_jal  = (op == 6'h03);
  assign rdy     = STALL_EN ? bus.mem_ready : 1'b1;
  assign unused_inst_bits = ^bus.inst[25:6];

  // ALU function table shared with the single-cycle decoder
  always_comb begin
    r_op = ALU_NOP; r_ok = 1'b1; r_shift = 1'b0;
    unique case (fn)
      6'h00: begin r_op = ALU_SLL; r_shift = 1'b1; end
      6'h02: begin r_op = ALU_SRL; r_shift = 1'b1; end
      6'h03: begin r_op = ALU_SRA; r_shift = 1'b1; end
      6'h04: r_op = ALU_SLL;
      6'h06: r_op = ALU_SRL;
      6'h07: r_op = ALU_SRA;
      6'h20, 6'h21: r_op = ALU_ADD;
      6'h22, 6'h23: r_op = ALU_SUB;
      6'h24: r_op = ALU_AND;
      6'h25: r_op = ALU_OR;
      6'h26: r_op = ALU_XOR;
      6'h27: r_op = ALU_NOR;
      6'h2A: r_op = ALU_SLT;
      6'h2B: r_op = ALU_SLTU;
      default: r_ok = 1'b0;
    endcase
    i_op = ALU_NOP; i_ok = 1'b1;
    unique case (op)
      6'h08: i_op = ALU_ADD;
      6'h0C: i_op = ALU_AND;
      6'h0D: i_op = ALU_OR;
      6'h0A: i_op = ALU_SLT;
      6'h0F: i_op = ALU_LUI;
      default: i_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bus.mem_read  = 1'b0; bus.mem_write = 1'b0; bus.iord = 1'b0;
    bus.ir_write  = 1'b0; bus.pc_write  = 1'b0; bus.pc_src = 2'd0;
    bus.alu_src_a = 2'd0; bus.alu_src_b = 2'd0; bus.alu_op = ALU_NOP;
    bus.reg_write = 1'b0; bus.reg_dst   = 2'd0; bus.reg_src = 2'd0;
    bus.retire    = 1'b0; bus.illegal   = 1'b0;
    // everything stays quiet while reset is held, whatever the state register shows
    if (rstn) begin
      unique case (state_q)
        S_FETCH: begin
          bus.mem_read = 1'b1; bus.alu_src_b = 2'd1; bus.alu_op = ALU_ADD;
          if (rdy) begin
            bus.ir_write = 1'b1; bus.pc_write = 1'b1; state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.alu_src_b = 2'd3; bus.alu_op = ALU_ADD;
          if (is_lw || is_sw)                         state_d = S_MEM_ADDR;
          else if (is_beq || is_bne)                  state_d = S_BRANCH;
          else if (is_j || is_jal || is_jr || is_jalr) state_d = S_JUMP;
          else if ((is_r && r_ok) || i_ok)            state_d = S_EXEC;
          else begin
            bus.illegal = 1'b1; state_d = S_FETCH;
          end
        end
        S_EXEC: begin
          bus.alu_src_a = (is_r && r_shift) ? 2'd2 : 2'd1;
          bus.alu_src_b = is_r ? 2'd0 : 2'd2;
          bus.alu_op    = is_r ? r_op : i_op;
          state_d       = S_ALU_WB;
        end
        S_ALU_WB: begin
          bus.reg_write = 1'b1; bus.reg_dst = is_r ? 2'd1 : 2'd0;
          bus.retire = 1'b1; state_d = S_FETCH;
        end
        S_MEM_ADDR: begin
          bus.alu_src_a = 2'd1; bus.alu_src_b = 2'd2; bus.alu_op = ALU_ADD;
          state_d = is_lw ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          bus.mem_read = 1'b1; bus.iord = 1'b1;
          if (rdy) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          bus.reg_write = 1'b1; bus.reg_src = 2'd1;
          bus.retire = 1'b1; state_d = S_FETCH;
        end
        S_MEM_WRITE: begin
          bus.mem_write = 1'b1; bus.iord = 1'b1;
          if (rdy) begin
            bus.retire = 1'b1; state_d = S_FETCH;
          end
        end
        S_BRANCH: begin
          bus.alu_src_a = 2'd1; bus.alu_op = ALU_SUB; bus.pc_src = 2'd1;
          bus.pc_write  = (is_beq && bus.zero) || (is_bne && !bus.zero);
          bus.retire = 1'b1; state_d = S_FETCH;
        end
        S_JUMP: begin
          bus.pc_write = 1'b1; bus.retire = 1'b1; state_d = S_FETCH;
          bus.pc_src   = (is_jr || is_jalr) ? 2'd3 : 2'd2;
          if (is_jal) begin
            bus.reg_write = 1'b1; bus.reg_dst = 2'd2; bus.reg_src = 2'd2;
          end else if (is_jalr) begin
            bus.reg_write = 1'b1; bus.reg_dst = 2'd1; bus.reg_src = 2'd2;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign inst_count_d   = inst_count_q + CNT_W'(bus.retire);
  assign bus.state      = state_q;
  assign bus.inst_count = inst_count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_FETCH;
      inst_count_q <= '0;
    end else begin
      state_q      <= state_d;
      inst_count_q <= inst_count_d;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle traces are built from the
// instruction class and checked cycle by cycle against the DUT.
module tb_multicycle_control;
  localparam int A_NOP = 0, A_ADD = 1, A_SUB = 2, A_AND = 3, A_OR = 4, A_XOR = 5,
                 A_NOR = 6, A_SLT = 7, A_SLTU = 8, A_SLL = 9, A_SRL = 10,
                 A_SRA = 11, A_LUI = 12;

  logic clk = 1'b0;
  logic rstn, rstn2;
  always #5 clk = ~clk;

  multicycle_control_if #(.ALUOP_W(4), .CNT_W(32)) bus ();
  multicycle_control #(.ALUOP_W(4), .STALL_EN(1'b1), .CNT_W(32))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  multicycle_control_if #(.ALUOP_W(4), .CNT_W(2)) bus2 ();
  multicycle_control #(.ALUOP_W(4), .STALL_EN(1'b0), .CNT_W(2))
    dut2 (.clk(clk), .rstn(rstn2), .bus(bus2));

  typedef struct {
    logic [31:0] inst; logic rdy; logic z;
    int st, mr, mw, iord, irw, pcw, pcs, sa, sb, op, rw, rd, rs, ret, ill;
    int unsigned cnt;
  } rec_t;

  typedef enum {C_R, C_SH, C_I, C_LW, C_SW, C_BR, C_J, C_ILL} cls_e;

  rec_t q[$];
  int errors = 0, checks = 0;
  int unsigned exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cls_e classify(input logic [31:0] i, output int aop);
    logic [5:0] op, fn;
    op = i[31:26]; fn = i[5:0]; aop = A_NOP;
    case (op)
      6'h00: case (fn)
        6'h00: begin aop = A_SLL; return C_SH; end
        6'h02: begin aop = A_SRL; return C_SH; end
        6'h03: begin aop = A_SRA; return C_SH; end
        6'h04: begin aop = A_SLL; return C_R; end
        6'h06: begin aop = A_SRL; return C_R; end
        6'h07: begin aop = A_SRA; return C_R; end
        6'h20, 6'h21: begin aop = A_ADD; return C_R; end
        6'h22, 6'h23: begin aop = A_SUB; return C_R; end
        6'h24: begin aop = A_AND; return C_R; end
        6'h25: begin aop = A_OR;  return C_R; end
        6'h26: begin aop = A_XOR; return C_R; end
        6'h27: begin aop = A_NOR; return C_R; end
        6'h2A: begin aop = A_SLT; return C_R; end
        6'h2B: begin aop = A_SLTU; return C_R; end
        6'h08, 6'h09: return C_J;
        default: return C_ILL;
      endcase
      6'h08: begin aop = A_ADD; return C_I; end
      6'h0C: begin aop = A_AND; return C_I; end
      6'h0D: begin aop = A_OR;  return C_I; end
      6'h0A: begin aop = A_SLT; return C_I; end
      6'h0F: begin aop = A_LUI; return C_I; end
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h04, 6'h05: return C_BR;
      6'h02, 6'h03: return C_J;
      default: return C_ILL;
    endcase
  endfunction

  function automatic rec_t base(input logic [31:0] ins, input int st, input logic rdy, input logic z);
    rec_t r;
    r.inst = ins; r.rdy = rdy; r.z = z; r.st = st;
    r.mr = 0; r.mw = 0; r.iord = 0; r.irw = 0; r.pcw = 0; r.pcs = 0; r.sa = 0; r.sb = 0;
    r.op = A_NOP; r.rw = 0; r.rd = 0; r.rs = 0; r.ret = 0; r.ill = 0; r.cnt = 0;
    return r;
  endfunction

  // the counter shows the old value during the retiring cycle
  task automatic push(input rec_t r);
    r.cnt = exp_cnt;
    q.push_back(r);
    if (r.ret != 0) exp_cnt++;
  endtask

  // fw/mw: wait cycles in FETCH / memory state; hang leaves the memory access stalled
  task automatic plan(input logic [31:0] ins, input int fw, input int mw, input logic z, input bit hang);
    rec_t r; cls_e c; int aop; logic [5:0] op, fn;
    c = classify(ins, aop); op = ins[31:26]; fn = ins[5:0];
    for (int k = 0; k <= fw; k++) begin
      r = base(32'hFFFF_FFFF, 0, (k == fw), 1'b0);
      r.mr = 1; r.sb = 1; r.op = A_ADD;
      if (k == fw) begin r.irw = 1; r.pcw = 1; end
      push(r);
    end
    r = base(ins, 1, 1'b1, z); r.sb = 3; r.op = A_ADD; r.ill = (c == C_ILL);
    push(r);
    case (c)
      C_R, C_SH, C_I: begin
        r = base(ins, 6, 1'b1, z); r.sa = (c == C_SH) ? 2 : 1; r.sb = (c == C_I) ? 2 : 0; r.op = aop;
        push(r);
        r = base(ins, 7, 1'b1, z); r.rw = 1; r.rd = (c == C_I) ? 0 : 1; r.ret = 1;
        push(r);
      end
      C_LW, C_SW: begin
        r = base(ins, 2, 1'b1, z); r.sa = 1; r.sb = 2; r.op = A_ADD;
        push(r);
        for (int k = 0; k < (hang ? mw : mw + 1); k++) begin
          r = base(ins, (c == C_LW) ? 3 : 5, (k == mw), z); r.iord = 1;
          if (c == C_LW) r.mr = 1; else begin r.mw = 1; r.ret = (k == mw); end
          push(r);
        end
        if (c == C_LW && !hang) begin
          r = base(ins, 4, 1'b1, z); r.rw = 1; r.rs = 1; r.ret = 1;
          push(r);
        end
      end
      C_BR: begin
        r = base(ins, 8, 1'b1, z); r.sa = 1; r.op = A_SUB; r.pcs = 1; r.ret = 1;
        r.pcw = (op == 6'h04) ? int'(z) : int'(!z);
        push(r);
      end
      C_J: begin
        r = base(ins, 9, 1'b1, z); r.pcw = 1; r.ret = 1; r.pcs = (op == 6'h00) ? 3 : 2;
        if (op == 6'h03) begin r.rw = 1; r.rd = 2; r.rs = 2; end
        if (op == 6'h00 && fn == 6'h09) begin r.rw = 1; r.rd = 1; r.rs = 2; end
        push(r);
      end
      default: ;
    endcase
  endtask

  task automatic run();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk); #1;
      bus.inst = r.inst; bus.mem_ready = r.rdy; bus.zero = r.z;
      #1;
      chk("state", bus.state, r.st);
      chk("mem_read", bus.mem_read, r.mr);
      chk("mem_write", bus.mem_write, r.mw);
      chk("iord", bus.iord, r.iord);
      chk("ir_write", bus.ir_write, r.irw);
      chk("pc_write", bus.pc_write, r.pcw);
      chk("pc_src", bus.pc_src, r.pcs);
      chk("alu_src_a", bus.alu_src_a, r.sa);
      chk("alu_src_b", bus.alu_src_b, r.sb);
      chk("alu_op", bus.alu_op, r.op);
      chk("reg_write", bus.reg_write, r.rw);
      chk("reg_dst", bus.reg_dst, r.rd);
      chk("reg_src", bus.reg_src, r.rs);
      chk("retire", bus.retire, r.ret);
      chk("illegal", bus.illegal, r.ill);
      chk("inst_count", bus.inst_count, r.cnt);
    end
  endtask

  initial begin
    rstn = 1'b0; rstn2 = 1'b0;
    bus.inst = 32'h0; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    bus2.inst = 32'h0022_1821; bus2.mem_ready = 1'b0; bus2.zero = 1'b0;
    #12;
    chk("rst_state", bus.state, 0);
    chk("rst_count", bus.inst_count, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_ir_write", bus.ir_write, 0);
    chk("rst_pc_write", bus.pc_write, 0);
    @(negedge clk); bus.mem_ready = 1'b0; rstn = 1'b1;

    plan(32'h0022_1821, 0, 0, 1'b0, 1'b0);
    chk("addu_len", q.size(), 4);
    run();
    chk("addu_cnt_model", exp_cnt, 1);
    plan(32'h8C22_0004, 0, 2, 1'b0, 1'b0);
    chk("lw_len", q.size(), 7);
    run();
    plan(32'hAC22_0004, 0, 1, 1'b0, 1'b0);
    chk("sw_len", q.size(), 5);
    run();
    plan(32'h1022_0003, 0, 0, 1'b1, 1'b0);
    chk("beq_len", q.size(), 3);
    run();
    plan(32'h1422_0003, 0, 0, 1'b1, 1'b0); run();
    plan(32'h1422_0003, 0, 0, 1'b0, 1'b0); run();
    plan(32'h3422_0FF0, 2, 0, 1'b0, 1'b0); run();
    plan(32'h0002_1080, 0, 0, 1'b0, 1'b0); run();
    plan(32'h0C00_0010, 0, 0, 1'b0, 1'b0); run();
    plan(32'h0020_F809, 0, 0, 1'b0, 1'b0); run();
    plan(32'h0800_0010, 0, 0, 1'b0, 1'b0); run();
    plan(32'h03E0_0008, 0, 0, 1'b0, 1'b0); run();
    plan(32'h3C01_1234, 0, 0, 1'b0, 1'b0); run();
    plan(32'h2822_000A, 0, 0, 1'b0, 1'b0); run();
    plan(32'h0022_182B, 0, 0, 1'b0, 1'b0); run();
    plan(32'hFC00_0000, 0, 0, 1'b0, 1'b0);
    chk("ill_len", q.size(), 2);
    run();
    plan(32'h0000_0001, 1, 0, 1'b0, 1'b0); run();
    chk("cnt_model_15", exp_cnt, 15);

    // reset asserted mid-write while memory is stalled
    plan(32'hAC22_0004, 0, 2, 1'b0, 1'b1); run();
    chk("sw_hold_mem_write", bus.mem_write, 1);
    rstn = 1'b0; #1;
    chk("rst_mw_drop", bus.mem_write, 0);
    chk("rst_mw_state", bus.state, 0);
    chk("rst_mw_count", bus.inst_count, 0);
    chk("rst_mw_retire", bus.retire, 0);
    exp_cnt = 0;
    @(negedge clk); bus.mem_ready = 1'b0; rstn = 1'b1;
    #1 chk("post_rst_state", bus.state, 0);
    plan(32'h0022_1821, 0, 0, 1'b0, 1'b0); run();

    // STALL_EN=0, CNT_W=2: mem_ready held low is ignored; five addu wrap the counter
    @(negedge clk); rstn2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      repeat (3) @(posedge clk);
      #1 chk("nostall_retire", bus2.retire, 1);
      @(posedge clk); #1;
      chk("nostall_state", bus2.state, 0);
      chk("nostall_count", bus2.inst_count, k % 4);
    end
    chk("wrap_count", bus2.inst_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
